// File: rtl/axis_dac_scheduler.sv
// axis_dac_scheduler
//   Plays back timestamped DAC words. Each 64-bit AXI-Stream beat carries
//   {dac_code, ts}. The word sits in a one-entry holding register until the
//   local time counter reaches ts. It is then driven to the DAC one clock
//   later, together with a single-cycle strobe. All logic runs in the
//   ADC/DAC clock domain.
//
// Ports
//   clk, reset        processing clock; asynchronous active-high reset
//   enable            run control; 0 = flush the hold and clear time
//   packet_size       expected beats per tlast packet (0 = no check)
//   s_axis_*          AXI-Stream slave (tdata/tvalid/tready/tlast/tkeep)
//   dac_out           registered DAC code
//   dac_strobe        1-cycle pulse when dac_out updates
//   time_now          local time counter (advances TIME_STEP per clk)
//   late_count        saturating count of words that fired late
//   words_played      wrapping count of fired words
//   pkt_err           sticky framing / tkeep error
//
// Handshake: a beat transfers on a rising clk edge where s_axis_tvalid and
// s_axis_tready are both 1. s_axis_tready is combinational. It is high
// when the block is enabled and either the hold is empty or the held word
// fires in this same cycle. A fire and an accept in the same cycle reload
// the hold without a bubble.
module axis_dac_scheduler #(
    parameter int DAC_W     = 14,
    parameter int TS_W      = 50,
    parameter int TIME_STEP = 8,
    parameter int LATE_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [31:0]       packet_size,
    input  logic [63:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic [7:0]        s_axis_tkeep,
    output logic [DAC_W-1:0]  dac_out,
    output logic              dac_strobe,
    output logic [TS_W-1:0]   time_now,
    output logic [LATE_W-1:0] late_count,
    output logic [31:0]       words_played,
    output logic              pkt_err
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [DAC_W-1:0]  hold_code;
    logic [TS_W-1:0]   hold_ts;
    logic              hold_new;     // first cycle of the current word in HOLD
    logic              enable_d;
    logic [31:0]       beat_cnt;
    logic [31:0]       pkt_size_q;

    logic              fire;
    logic              accept;
    logic              late_now;
    logic [31:0]       size_eff;
    logic              at_last;
    logic              frame_bad;

    // ------------------------------------------------------------------
    // Next-state and combinational controls
    // ------------------------------------------------------------------
    always_comb begin
        fire          = 1'b0;
        s_axis_tready = 1'b0;
        accept        = 1'b0;
        late_now      = 1'b0;
        state_next    = state;

        // A disabled block never fires; its hold is simply dropped.
        fire = enable && (state == ST_HOLD) && (time_now >= hold_ts);
        // Reset is included so tready reads 0 while reset is asserted.
        s_axis_tready = enable && !reset && ((state == ST_EMPTY) || fire);
        accept        = s_axis_tvalid && s_axis_tready;
        late_now      = fire && hold_new && (hold_ts < time_now);

        if (!enable) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept)          state_next = ST_HOLD;
                ST_HOLD:  if (fire && !accept) state_next = ST_EMPTY;
                default:                       state_next = ST_EMPTY;
            endcase
        end
    end

    // Framing: the packet length is taken from packet_size on the first
    // beat of a packet and held in pkt_size_q for the remaining beats.
    always_comb begin
        size_eff  = (beat_cnt == 32'd0) ? packet_size : pkt_size_q;
        at_last   = (size_eff != 32'd0) && (beat_cnt == size_eff - 32'd1);
        frame_bad = accept &&
                    (((size_eff != 32'd0) && (s_axis_tlast != at_last)) ||
                     (s_axis_tkeep != 8'hFF));
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Time base
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            time_now <= '0;
        end else if (enable) begin
            time_now <= time_now + TS_W'(TIME_STEP);
        end else begin
            time_now <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Holding register and playback outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_code    <= '0;
            hold_ts      <= '0;
            hold_new     <= 1'b0;
            dac_out      <= '0;
            dac_strobe   <= 1'b0;
            words_played <= '0;
            late_count   <= '0;
        end else begin
            hold_new   <= accept;
            dac_strobe <= fire;
            if (accept) begin
                hold_code <= s_axis_tdata[63 -: DAC_W];
                hold_ts   <= s_axis_tdata[TS_W-1:0];
            end
            if (fire) begin
                dac_out      <= hold_code;
                words_played <= words_played + 32'd1;
            end
            if (late_now && (late_count != {LATE_W{1'b1}})) begin
                late_count <= late_count + LATE_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Framing check
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_d   <= 1'b0;
            beat_cnt   <= '0;
            pkt_size_q <= '0;
            pkt_err    <= 1'b0;
        end else begin
            enable_d <= enable;
            // A flush abandons any partial packet.
            if (!enable) begin
                beat_cnt <= '0;
            end else if (accept) begin
                if (beat_cnt == 32'd0) begin
                    pkt_size_q <= packet_size;
                end
                if (s_axis_tlast || at_last) begin
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 32'd1;
                end
            end
            // A new error on the re-enable cycle wins over the clear.
            if (frame_bad) begin
                pkt_err <= 1'b1;
            end else if (enable && !enable_d) begin
                pkt_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_dac_scheduler.sv
// tb_axis_dac_scheduler
//   Bench for axis_dac_scheduler. A driver pushes the expected playback
//   event ({late, code, fire_time}) for every accepted beat. A monitor pops
//   one event for every dac_strobe and compares it with the DUT outputs.
module tb_axis_dac_scheduler;
  localparam int DAC_W  = 14;
  localparam int TS_W   = 50;
  localparam int LATE_W = 16;
  localparam int STEP   = 8;
  localparam int EW     = 1 + DAC_W + TS_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [31:0]       packet_size = '0;
  logic [63:0]       s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic              s_axis_tlast = 1'b0;
  logic [7:0]        s_axis_tkeep = 8'hFF;
  logic [DAC_W-1:0]  dac_out;
  logic              dac_strobe;
  logic [TS_W-1:0]   time_now;
  logic [LATE_W-1:0] late_count;
  logic [31:0]       words_played;
  logic              pkt_err;

  axis_dac_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .packet_size(packet_size),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tkeep(s_axis_tkeep), .dac_out(dac_out), .dac_strobe(dac_strobe),
    .time_now(time_now), .late_count(late_count),
    .words_played(words_played), .pkt_err(pkt_err)
  );

  // ---------------- clock / reset / time model ----------------
  always #5 clk = ~clk;

  logic [TS_W-1:0] tb_time;
  always @(posedge clk or posedge reset) begin
    if (reset) tb_time <= '0;
    else if (enable) tb_time <= tb_time + TS_W'(STEP);
    else tb_time <= '0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  int exp_played = 0;
  int exp_late = 0;
  logic [DAC_W-1:0] exp_last_code = '0;
  logic exp_err = 1'b0;
  int pkt_pos = 0;
  logic [31:0] pkt_sz = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int mon_cyc = 0;
  logic [EW-1:0] mon_e;
  always @(negedge clk) begin
    if (!reset) begin
      mon_cyc++;
      if (mon_cyc % 16 == 0) check("time_now", 64'(time_now), 64'(tb_time));
      if (dac_strobe) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe dac_out=%0h expected no strobe", dac_out);
        end else begin
          mon_e = exp_q.pop_front();
          exp_played++;
          if (mon_e[EW-1]) exp_late++;
          exp_last_code = mon_e[TS_W +: DAC_W];
          check("dac_out", 64'(dac_out), 64'(mon_e[TS_W +: DAC_W]));
          check("fire_time", 64'(tb_time) - 64'(STEP), 64'(mon_e[TS_W-1:0]));
          check("words_played", 64'(words_played), 64'(exp_played));
          check("late_count", 64'(late_count), 64'(exp_late));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_enable(input logic v);
    if (v && !enable) exp_err = 1'b0;
    if (!v) pkt_pos = 0;
    enable = v;
  endtask

  // Presents one beat and returns the time_now value of its accept cycle.
  task automatic send_beat(input logic [DAC_W-1:0] code, input logic [TS_W-1:0] ts,
                           input logic last, input logic [7:0] keep,
                           output logic [TS_W-1:0] t_acc);
    int wait_cyc = 0;
    logic [TS_W-1:0] first_hold, due, fire_t;
    logic at_end;
    s_axis_tdata  = {code, ts};
    s_axis_tlast  = last;
    s_axis_tkeep  = keep;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && wait_cyc < 5000) begin
      wait_cyc++;
      @(negedge clk);
    end
    if (!s_axis_tready) begin
      checks++;
      failures++;
      $display("FAIL tready_timeout tready=0 expected 1 within 5000 cycles");
      s_axis_tvalid = 1'b0;
      t_acc = '0;
      return;
    end
    t_acc = tb_time;
    // Word is first in HOLD one clock after the accept; it fires at the
    // first time_now value (multiple of STEP) that reaches ts.
    first_hold = t_acc + TS_W'(STEP);
    due = ((ts + TS_W'(STEP - 1)) / TS_W'(STEP)) * TS_W'(STEP);
    fire_t = (due > first_hold) ? due : first_hold;
    exp_q.push_back({(ts < first_hold), code, fire_t});
    if (pkt_pos == 0) pkt_sz = packet_size;
    at_end = (pkt_sz != 0) && (pkt_pos == int'(pkt_sz) - 1);
    if (((pkt_sz != 0) && (last != at_end)) || (keep != 8'hFF)) exp_err = 1'b1;
    pkt_pos = (last || at_end) ? 0 : pkt_pos + 1;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tkeep  = 8'hFF;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_queue", 64'(exp_q.size()), 64'd0);
    wait_cycles(2);
  endtask

  // ---------------- stimulus ----------------
  logic [TS_W-1:0] ta, ta2, ta3, ts_r;
  initial begin
    // Reset state
    wait_cycles(3);
    check("rst_dac_out", 64'(dac_out), 64'd0);
    check("rst_strobe", 64'(dac_strobe), 64'd0);
    check("rst_time_now", 64'(time_now), 64'd0);
    check("rst_late", 64'(late_count), 64'd0);
    check("rst_played", 64'(words_played), 64'd0);
    check("rst_pkt_err", 64'(pkt_err), 64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    reset = 1'b0;
    wait_cycles(1);
    set_enable(1'b1);

    // T1: single on-time word
    send_beat(14'h1234, 50'd40, 1'b1, 8'hFF, ta);
    wait_drain();
    check("t1_dac_out", 64'(dac_out), 64'h1234);
    check("t1_played", 64'(words_played), 64'd1);
    check("t1_late", 64'(late_count), 64'd0);

    // T2: back-to-back words, reload on the fire cycle
    send_beat(14'h0101, 50'd800, 1'b1, 8'hFF, ta);
    send_beat(14'h0202, 50'd1600, 1'b1, 8'hFF, ta2);
    send_beat(14'h0303, 50'd2400, 1'b1, 8'hFF, ta3);
    check("t2_accept2_time", 64'(ta2), 64'd800);
    check("t2_accept3_time", 64'(ta3), 64'd1600);
    wait_drain();
    check("t2_played", 64'(words_played), 64'd4);

    // T3: late word
    wait_cycles(200);
    send_beat(14'h2AAA, 50'd16, 1'b1, 8'hFF, ta);
    wait_drain();
    check("t3_late", 64'(late_count), 64'd1);
    check("t3_dac_out", 64'(dac_out), 64'h2AAA);

    // T4: framing
    packet_size = 32'd4;
    for (int b = 0; b < 3; b++) send_beat(14'(16 + b), 50'd0, (b == 2), 8'hFF, ta);
    wait_drain();
    check("t4_short_pkt_err", 64'(pkt_err), 64'd1);
    for (int b = 0; b < 4; b++) send_beat(14'(32 + b), 50'd0, (b == 3), 8'hFF, ta);
    wait_drain();
    check("t4_sticky_pkt_err", 64'(pkt_err), 64'(exp_err));
    set_enable(1'b0);
    wait_cycles(2);
    set_enable(1'b1);
    wait_cycles(2);
    check("t4_cleared_pkt_err", 64'(pkt_err), 64'd0);
    for (int b = 0; b < 4; b++) send_beat(14'(48 + b), 50'd0, (b == 3), 8'hFF, ta);
    wait_drain();
    check("t4_good_pkt_err", 64'(pkt_err), 64'd0);
    packet_size = 32'd0;
    send_beat(14'h0F0F, 50'd0, 1'b1, 8'h0F, ta);
    wait_drain();
    check("t4_tkeep_pkt_err", 64'(pkt_err), 64'd1);
    check("t4_tkeep_played", 64'(dac_out), 64'h0F0F);

    // Random packets with matching tlast and random timestamps
    set_enable(1'b0);
    wait_cycles(1);
    set_enable(1'b1);
    for (int p = 0; p < 10; p++) begin
      int sz;
      sz = $urandom_range(1, 5);
      packet_size = 32'(sz);
      for (int b = 0; b < sz; b++) begin
        ts_r = tb_time + TS_W'($urandom_range(0, 400));
        if ($urandom_range(0, 3) == 0) ts_r = (tb_time > 50'd40) ? tb_time - TS_W'($urandom_range(0, 40)) : '0;
        send_beat(14'($urandom), ts_r, (b == sz - 1), 8'hFF, ta);
        wait_cycles($urandom_range(0, 3));
      end
    end
    wait_drain();
    check("rnd_pkt_err", 64'(pkt_err), 64'(exp_err));
    check("rnd_played", 64'(words_played), 64'(exp_played));
    check("rnd_late", 64'(late_count), 64'(exp_late));

    // T5: disable while holding a far-future word
    packet_size = 32'd0;
    send_beat(14'h0777, tb_time + 50'd100000, 1'b1, 8'hFF, ta);
    wait_cycles(5);
    set_enable(1'b0);
    exp_q.delete();
    @(negedge clk);
    check("t5_tready_off", 64'(s_axis_tready), 64'd0);
    wait_cycles(3);
    check("t5_time_now", 64'(time_now), 64'd0);
    check("t5_dac_hold", 64'(dac_out), 64'(exp_last_code));
    check("t5_played_kept", 64'(words_played), 64'(exp_played));
    set_enable(1'b1);
    send_beat(14'h0555, 50'd24, 1'b1, 8'hFF, ta);
    wait_drain();
    check("t5_reenable_dac", 64'(dac_out), 64'h0555);

    // T6: reset while holding
    send_beat(14'h3FFF, tb_time + 50'd100000, 1'b1, 8'hFF, ta);
    wait_cycles(3);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    exp_played = 0;
    exp_late = 0;
    exp_err = 1'b0;
    exp_last_code = '0;
    pkt_pos = 0;
    check("t6_dac_out", 64'(dac_out), 64'd0);
    check("t6_time_now", 64'(time_now), 64'd0);
    check("t6_played", 64'(words_played), 64'd0);
    check("t6_late", 64'(late_count), 64'd0);
    check("t6_pkt_err", 64'(pkt_err), 64'd0);
    check("t6_tready", 64'(s_axis_tready), 64'd0);
    wait_cycles(3);
    check("t6_tready_held", 64'(s_axis_tready), 64'd0);
    reset = 1'b0;
    wait_cycles(1);
    send_beat(14'h0ABC, 50'd32, 1'b1, 8'hFF, ta);
    wait_drain();
    check("t6_after_played", 64'(words_played), 64'd1);
    check("t6_after_dac", 64'(dac_out), 64'h0ABC);

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
